prbs_pattern_gen: RTL
=====================

// Module: prbs_pattern_gen
// PURPOSE
//  Parametrised test-pattern source for the pattern-detector datapath. On start it emits a
//  user pattern N times as OUT_W-bit words, then PRBS_WORDS words of a selectable PRBS
//  (7/15/23/31). Output uses a valid/ready stream so downstream detectors can stall it.
//  This is the successor of the fixed 32-bit/PRBS-15 byte generator.
// PARAMETERS
//  PAT_W   32            pattern width; must be an integer multiple of OUT_W
//  OUT_W   8             output word width, also LFSR steps per word
//  CNT_W   8             width of the repeat count n
//  LEN_W   16            width of the PRBS word count
//  SEED    31'h7FFFFFFF  LFSR seed, masked to the active polynomial length; must be non-zero
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      one-cycle request; sampled only in IDLE
//  abort       in   1      synchronous stop; returns the block to IDLE
//  seq         in   PAT_W  pattern, latched at start
//  n           in   CNT_W  pattern repeat count, latched at start
//  mode        in   2      0:x^7+x^6+1  1:x^15+x^14+1  2:x^23+x^18+1  3:x^31+x^28+1
//  prbs_words  in   LEN_W  number of PRBS words after the pattern phase, latched at start
//  out_data    out  OUT_W  stream data
//  out_valid   out  1      stream valid
//  out_ready   in   1      stream ready
//  busy        out  1      high in PAT and PRBS states
//  done        out  1      one-cycle pulse when a run completes
// BEHAVIOUR
//  - Reset: state=IDLE; out_data=0, out_valid=0, busy=0, done=0; counters 0; LFSR=SEED.
//  - FSM states: IDLE, PAT, PRBS. Every output is registered.
//  - IDLE + start: latch seq, n, mode and prbs_words; load LFSR with masked SEED.
//    next = PAT if n!=0, else PRBS if prbs_words!=0.
//    If both are 0: stay in IDLE and pulse done on the next cycle; out_valid never rises.
//  - First out_valid appears in the cycle after start (latency 1).
//  - Handshake: a word transfers when out_valid && out_ready.
//    While out_valid && !out_ready, out_data and out_valid hold.
//    After a transfer the next word is presented in the following cycle, so there are
//    no bubbles while ready stays high.
//  - PAT: words are issued MSB-first: seq[PAT_W-1 -: OUT_W] first, W = PAT_W/OUT_W words
//    per repetition. The word index wraps W-1 -> 0 and the repeat counter increments.
//    After the last word of repetition n: go to PRBS if prbs_words!=0, else finish.
//  - PRBS: Fibonacci LFSR of length L (7/15/23/31). Per step: fb = s[L-1]^s[tap-1];
//    s <= {s[L-2:0], fb}. One word = OUT_W consecutive fb bits, with the first bit in
//    the MSB. The LFSR advances OUT_W steps only on a transfer.
//    After prbs_words transfers: finish.
//  - Finish: done pulses one cycle after the last transfer, coincident with out_valid=0,
//    busy=0, state=IDLE.
//  - start while busy is ignored. Inputs other than start, abort and out_ready are
//    ignored outside IDLE.
//  - abort, or rst, mid-run: next cycle out_valid=0, busy=0, state=IDLE, no done pulse.
//    abort has priority over a simultaneous transfer. abort in IDLE has no effect.
//    start and abort together in IDLE: abort wins and start is dropped.
//  - Counters saturate never. Maximum run length = n*W + prbs_words words.
// TESTING
//  1 seq=32'hABCDEF23, n=2, prbs_words=1, mode=0, ready=1 -> data AB CD EF 23 AB CD EF 23 02
//    on 9 consecutive valid cycles; done pulses 1 cycle after the 02 transfer.
//  2 Same run with ready toggled 1-0-0-1 pseudo-randomly -> identical data sequence;
//    data is held stable through every stall; no word is lost or duplicated.
//  3 n=0, prbs_words=0, start -> out_valid stays 0; done pulses exactly once, 1 cycle after start.
//  4 mode=0, n=0, prbs_words=254 -> word[k+127]==word[k] for k=0..126; word[0]=8'h02.
//  5 mode=1..3, n=0, prbs_words=4096 -> every word matches the bench's bit-serial LFSR model.
//  6 abort, then rst, asserted during PAT word 3 -> out_valid=0 next cycle, no done pulse;
//    a new start then replays from word 0 with a fresh seed.

Source files
------------

// File: rtl/prbs_pattern_gen_if.sv
// Valid/ready output stream of the PRBS pattern generator.
// The generator drives data/valid and the downstream detector drives ready.
interface prbs_pattern_gen_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/prbs_pattern_gen.sv
// Test-pattern source: a user pattern repeated n times, then prbs_words words of a
// selectable Fibonacci PRBS (7/15/23/31), all on a stallable valid/ready stream.
module prbs_pattern_gen #(
  parameter int          PAT_W = 32,
  parameter int          OUT_W = 8,
  parameter int          CNT_W = 8,
  parameter int          LEN_W = 16,
  parameter logic [30:0] SEED  = 31'h7FFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PAT_W-1:0]     seq,
  input  logic [CNT_W-1:0]     n,
  input  logic [1:0]           mode,
  input  logic [LEN_W-1:0]     prbs_words,
  prbs_pattern_gen_if.master   strm,
  output logic                 busy,
  output logic                 done
);

  localparam int W     = PAT_W / OUT_W;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAT,
    S_PRBS
  } state_t;

  typedef struct packed {
    logic [30:0]      lfsr;
    logic [OUT_W-1:0] word;
  } prbs_step_t;

  function automatic logic [30:0] len_mask(input logic [1:0] m);
    logic [30:0] msk;
    case (m)
      2'd0:    msk = 31'h0000007F;
      2'd1:    msk = 31'h00007FFF;
      2'd2:    msk = 31'h007FFFFF;
      default: msk = 31'h7FFFFFFF;
    endcase
    return msk;
  endfunction

  // Advance the LFSR OUT_W steps; the first feedback bit lands in the word MSB.
  function automatic prbs_step_t prbs_step(input logic [30:0] s, input logic [1:0] m);
    prbs_step_t r;
    logic       fb;
    r.lfsr = s;
    r.word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (m)
        2'd0:    fb = r.lfsr[6]  ^ r.lfsr[5];
        2'd1:    fb = r.lfsr[14] ^ r.lfsr[13];
        2'd2:    fb = r.lfsr[22] ^ r.lfsr[17];
        default: fb = r.lfsr[30] ^ r.lfsr[27];
      endcase
      r.lfsr = {r.lfsr[29:0], fb} & len_mask(m);
      r.word[OUT_W-1-i] = fb;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] pat_word(input logic [PAT_W-1:0] p,
                                                input logic [IDX_W-1:0] i);
    logic [PAT_W-1:0] sh;
    sh = p << (OUT_W * i);
    return sh[PAT_W-1 -: OUT_W];
  endfunction

  state_t           state;
  logic [PAT_W-1:0] seq_q;
  logic [CNT_W-1:0] n_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] prbs_words_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rep;
  logic [LEN_W-1:0] prbs_cnt;
  logic [30:0]      lfsr;

  logic             xfer;
  logic [IDX_W-1:0] idx_next;
  logic             pat_last;
  logic             prbs_last;
  logic [30:0]      step_src;
  logic [1:0]       step_mode;
  prbs_step_t       step;

  // NOTE: every signal written in always_comb gets a value on every path (defaults
  // first), otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    xfer      = strm.out_valid && strm.out_ready;
    idx_next  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    pat_last  = (idx == LAST_IDX) && (rep == n_q - 1'b1);
    prbs_last = (prbs_cnt == prbs_words_q - 1'b1);
    // In IDLE the first PRBS word comes straight from the freshly masked seed.
    step_src  = lfsr;
    step_mode = mode_q;
    if (state == S_IDLE) begin
      step_src  = SEED & len_mask(mode);
      step_mode = mode;
    end
    step = prbs_step(step_src, step_mode);
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      seq_q          <= '0;
      n_q            <= '0;
      mode_q         <= '0;
      prbs_words_q   <= '0;
      idx            <= '0;
      rep            <= '0;
      prbs_cnt       <= '0;
      lfsr           <= SEED;
      strm.out_data  <= '0;
      strm.out_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Abort wins over a transfer in the same cycle and never raises done.
        state          <= S_IDLE;
        strm.out_valid <= 1'b0;
        busy           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              seq_q        <= seq;
              n_q          <= n;
              mode_q       <= mode;
              prbs_words_q <= prbs_words;
              idx          <= '0;
              rep          <= '0;
              prbs_cnt     <= '0;
              lfsr         <= SEED & len_mask(mode);
              if (n != '0) begin
                state          <= S_PAT;
                strm.out_data  <= pat_word(seq, '0);
                strm.out_valid <= 1'b1;
                busy           <= 1'b1;
              end else if (prbs_words != '0) begin
                state          <= S_PRBS;
                strm.out_data  <= step.word;
                lfsr           <= step.lfsr;
                strm.out_valid <= 1'b1;
                busy           <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end

          S_PAT: begin
            if (xfer) begin
              if (pat_last) begin
                if (prbs_words_q != '0) begin
                  state         <= S_PRBS;
                  strm.out_data <= step.word;
                  lfsr          <= step.lfsr;
                end else begin
                  state          <= S_IDLE;
                  strm.out_valid <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                end
              end else begin
                idx           <= idx_next;
                strm.out_data <= pat_word(seq_q, idx_next);
                if (idx == LAST_IDX) begin
                  rep <= rep + 1'b1;
                end
              end
            end
          end

          S_PRBS: begin
            if (xfer) begin
              if (prbs_last) begin
                state          <= S_IDLE;
                strm.out_valid <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
              end else begin
                prbs_cnt      <= prbs_cnt + 1'b1;
                strm.out_data <= step.word;
                lfsr          <= step.lfsr;
              end
            end
          end

          default: begin
            state          <= S_IDLE;
            strm.out_valid <= 1'b0;
            busy           <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
